// File: rtl/spw_rx_pio_bridge.sv
// spw_rx_pio_bridge: buffers SpaceWire RX chars in a FIFO and hands them to software over a 4-phase valid/ack PIO handshake
module spw_rx_pio_bridge #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [8:0]  spw_rx_data,
    input  logic        spw_rx_valid,
    output logic        spw_rx_ready,
    output logic [8:0]  pio_data_rx_r,
    output logic        pio_data_rx_valid,
    input  logic        pio_rx_ack,
    input  logic        overflow_clr,
    output logic        overflow,
    output logic [AW:0] fill_count
);
    localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    typedef enum logic [1:0] {EMPTY, LOAD, PRESENT, WAIT_LOW} state_t;
    state_t        state_q;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [8:0]    data_q;
    logic          valid_q, overflow_q, overflow_d, ack_q, ack_armed_q;
    logic          full, push, pop, ack_rise, ack_fall;
    assign spw_rx_ready      = ~full;
    assign pio_data_rx_r     = data_q;
    assign pio_data_rx_valid = valid_q;
    assign overflow          = overflow_q;
    assign fill_count        = count_q;
    // next-state for pointers, occupancy and the sticky overflow; fullness uses the pre-pop count
    always_comb begin
        full       = count_q == FULL;
        push       = spw_rx_valid & ~full;
        ack_rise   = pio_rx_ack & ~ack_q;
        ack_fall   = ~pio_rx_ack & ack_q;
        pop        = (state_q == PRESENT) & ack_rise & ack_armed_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = (push & ~pop) ? count_q + CNT_ONE : (pop & ~push) ? count_q - CNT_ONE : count_q;
        overflow_d = (spw_rx_valid & full) | (~overflow_clr & overflow_q);
    end
    // FIFO bookkeeping and ack history
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ack_q      <= pio_rx_ack;
        end
    end
    // storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr_q] <= spw_rx_data;
    end
    // presentation FSM; ack must be seen low around a presentation before a rise pops, so a stale ack held through reset is ignored
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= EMPTY;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ack_armed_q <= 1'b0;
        end else begin
            ack_armed_q <= ack_armed_q | (((state_q == LOAD) | (state_q == PRESENT)) & ~pio_rx_ack);
            case (state_q)
                EMPTY:    if (count_q != '0) state_q <= LOAD;
                LOAD: begin
                    data_q  <= mem[rd_ptr_q];
                    valid_q <= 1'b1;
                    state_q <= PRESENT;
                end
                PRESENT: if (pop) begin
                    valid_q <= 1'b0;
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: if (ack_fall) state_q <= (count_q != '0) ? LOAD : EMPTY;
                default:  state_q <= EMPTY;
            endcase
        end
    end
endmodule
